uart_rx_deframer: RTL and testbench

Downstream stage of the UART byte receiver. Consumes received bytes through the receiver's rdy / rdy_clr / data handshake. Parses them into checksummed frames (SOF 0x7E, LEN, payload, CHK). Stores payload speculatively in a circular buffer and releases a frame to a valid/ready byte stream only after its checksum passes; bad frames are rolled back.

---
 rtl/uart_rx_deframer.sv | 149 ++++++++++++++
 tb/tb_uart_rx_deframer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// Frame parser behind the UART byte receiver: SOF 0x7E, LEN, payload, CHK.
// Payload is staged in a circular buffer and released only once its checksum passes.
module uart_rx_deframer #(
    parameter int DEPTH_LOG2 = 5,
    parameter int MAX_LEN    = 16,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_rdy_clr,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr, cm_ptr, rd_ptr;
    logic [8:0]      mem [DEPTH];
    logic [7:0]      sum, remaining, chk_sum;
    logic [31:0]     timer;
    logic            capture, pop, full, timeout_hit, bad_len;
    logic            do_write, do_commit, do_rollback, err_nxt;
    logic [1:0]      code_nxt;

    assign capture   = rx_rdy && !rx_rdy_clr;
    assign out_valid = (rd_ptr != cm_ptr);
    assign pop       = out_valid && out_ready;
    // An entry freed on this same edge makes room for a concurrent write.
    assign full      = ((wr_ptr - rd_ptr) == PW'(DEPTH)) && !pop;
    assign bad_len   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign chk_sum   = sum + rx_data;
    assign busy      = (state != HUNT);
    assign timeout_hit = (TIMEOUT != 0) && (state != HUNT) && !capture &&
                         (timer == 32'(TIMEOUT - 1));

    // Gated so the port reads zero while nothing committed is pending.
    assign out_data  = out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]][7:0] : 8'd0;
    assign out_last  = out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]][8]   : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (capture) begin
            case (state)
                HUNT:    if (rx_data == 8'h7E) state_nxt = LEN;
                LEN:     state_nxt = bad_len ? HUNT : PAYLOAD;
                PAYLOAD: begin
                    if (full)                     state_nxt = HUNT;
                    else if (remaining == 8'd1)   state_nxt = CHK;
                end
                CHK:     state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end else if (timeout_hit) begin
            state_nxt = HUNT;
        end
    end

    always_comb begin
        do_write    = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        err_nxt     = 1'b0;
        code_nxt    = 2'd0;
        if (capture) begin
            case (state)
                LEN: if (bad_len) begin
                    err_nxt  = 1'b1;
                    code_nxt = 2'd0;
                end
                PAYLOAD: begin
                    if (full) begin
                        err_nxt     = 1'b1;
                        code_nxt    = 2'd2;
                        do_rollback = 1'b1;
                    end else begin
                        do_write = 1'b1;
                    end
                end
                CHK: begin
                    if (chk_sum == 8'd0) begin
                        do_commit = 1'b1;
                    end else begin
                        err_nxt     = 1'b1;
                        code_nxt    = 2'd1;
                        do_rollback = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout_hit) begin
            err_nxt     = 1'b1;
            code_nxt    = 2'd3;
            do_rollback = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_clr <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            wr_ptr     <= '0;
            cm_ptr     <= '0;
            rd_ptr     <= '0;
            sum        <= 8'd0;
            remaining  <= 8'd0;
            timer      <= 32'd0;
        end else begin
            rx_rdy_clr <= capture;
            err        <= err_nxt;
            err_code   <= code_nxt;
            if (do_rollback)    wr_ptr <= cm_ptr;
            else if (do_write)  wr_ptr <= wr_ptr + 1'b1;
            if (do_commit)      cm_ptr <= wr_ptr;
            if (pop)            rd_ptr <= rd_ptr + 1'b1;
            if (capture && state == LEN) begin
                sum       <= rx_data;
                remaining <= rx_data;
            end else if (do_write) begin
                sum       <= chk_sum;
                remaining <= remaining - 8'd1;
            end
            if (capture || state == HUNT) timer <= 32'd0;
            else if (TIMEOUT != 0)        timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {remaining == 8'd1, rx_data};
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: good/bad frames, overflow, timeout,
// back-to-back receiver bytes and mid-frame reset.
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_rdy_clr;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int err_count = 0;

    uart_rx_deframer #(.DEPTH_LOG2(5), .MAX_LEN(16), .TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(rx_rdy_clr),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready),
        .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (err === 1'b1) err_count <= err_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    initial begin
        logic [7:0] b2b [5];
        int e0;
        logic [7:0] exp_d;

        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clr",   rx_rdy_clr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last",  out_last, 0);
        check("rst_data",  out_data, 0);
        check("rst_err",   err, 0);
        check("rst_code",  err_code, 0);
        check("rst_busy",  busy, 0);
        rst_n = 1'b1;

        // Good frame, sink always ready
        send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        check("t1_hidden", out_valid, 0);
        check("t1_busy",   busy, 1);
        send(8'h97);
        check("t1_v0", out_valid, 1); check("t1_d0", out_data, 8'h11); check("t1_l0", out_last, 0);
        check("t1_busy_end", busy, 0);
        @(negedge clk);
        check("t1_v1", out_valid, 1); check("t1_d1", out_data, 8'h22); check("t1_l1", out_last, 0);
        @(negedge clk);
        check("t1_v2", out_valid, 1); check("t1_d2", out_data, 8'h33); check("t1_l2", out_last, 1);
        @(negedge clk);
        check("t1_empty", out_valid, 0);
        check("t1_noerr", err_count, 0);

        // Bad checksum, then a one-byte frame
        send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
        check("t2_err", err, 1); check("t2_code", err_code, 1); check("t2_valid", out_valid, 0);
        @(negedge clk);
        check("t2_pulse", err, 0); check("t2_valid2", out_valid, 0);
        send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
        check("t2_v", out_valid, 1); check("t2_d", out_data, 8'hAA); check("t2_l", out_last, 1);
        @(negedge clk);
        check("t2_empty", out_valid, 0);

        // Junk byte and illegal lengths
        e0 = err_count;
        send(8'hA5); check("t3_ignore", busy, 0);
        send(8'h7E); check("t3_sof", busy, 1);
        send(8'h00); check("t3_err0", err, 1); check("t3_code0", err_code, 0); check("t3_hunt", busy, 0);
        send(8'h7E); send(8'h11);
        check("t3_err1", err, 1); check("t3_code1", err_code, 0);
        @(negedge clk);
        check("t3_count", err_count - e0, 2); check("t3_valid", out_valid, 0);

        // Overflow: two 16-byte frames fill the buffer, third is rejected
        out_ready = 1'b0;
        e0 = err_count;
        send(8'h7E); send(8'h10);
        for (int k = 1; k <= 16; k++) send(8'(k));
        send(8'h68);
        send(8'h7E); send(8'h10);
        for (int k = 1; k <= 16; k++) send(8'(8'h20 + k));
        send(8'h68);
        check("t4_commit", out_valid, 1); check("t4_noerr", err_count - e0, 0);
        send(8'h7E); send(8'h10); send(8'h01);
        check("t4_err", err, 1); check("t4_code", err_code, 2); check("t4_hunt", busy, 0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_d = (i < 16) ? 8'(i + 1) : 8'(8'h20 + i - 15);
            check($sformatf("t4_v%0d", i), out_valid, 1);
            check($sformatf("t4_d%0d", i), out_data, exp_d);
            check($sformatf("t4_l%0d", i), out_last, (i == 15 || i == 31) ? 1 : 0);
            @(negedge clk);
        end
        check("t4_empty", out_valid, 0);

        // Inter-byte timeout
        send(8'h7E); send(8'h02); send(8'h11);
        repeat (49) @(negedge clk);
        check("t5_early", err, 0); check("t5_busy", busy, 1);
        @(negedge clk);
        check("t5_err", err, 1); check("t5_code", err_code, 3); check("t5_hunt", busy, 0);
        send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
        check("t5_v", out_valid, 1); check("t5_d", out_data, 8'hAA); check("t5_l", out_last, 1);
        @(negedge clk);
        check("t5_empty", out_valid, 0);

        // Receiver re-asserts rdy during the clear cycle
        e0 = err_count;
        b2b[0] = 8'h7E; b2b[1] = 8'h02; b2b[2] = 8'h11; b2b[3] = 8'h22; b2b[4] = 8'hCB;
        @(negedge clk);
        rx_data = b2b[0];
        rx_rdy  = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t6_clr%0d", i), rx_rdy_clr, 1);
            rx_data = b2b[i];
            @(negedge clk);
        end
        @(negedge clk);
        rx_rdy = 1'b0;
        check("t6_v0", out_valid, 1); check("t6_d0", out_data, 8'h11); check("t6_l0", out_last, 0);
        @(negedge clk);
        check("t6_v1", out_valid, 1); check("t6_d1", out_data, 8'h22); check("t6_l1", out_last, 1);
        @(negedge clk);
        check("t6_empty", out_valid, 0); check("t6_noerr", err_count - e0, 0);

        // Reset mid-payload with committed data pending
        out_ready = 1'b0;
        send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
        check("t7_pending", out_valid, 1);
        send(8'h7E); send(8'h03); send(8'h11);
        check("t7_busy", busy, 1); check("t7_clr", rx_rdy_clr, 1);
        rst_n = 1'b0;
        #1;
        check("t7_rvalid", out_valid, 0); check("t7_rbusy", busy, 0);
        check("t7_rclr", rx_rdy_clr, 0); check("t7_rdata", out_data, 0);
        check("t7_rlast", out_last, 0); check("t7_rerr", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'h7E); send(8'h01); send(8'hBB); send(8'h44);
        check("t7_v", out_valid, 1); check("t7_d", out_data, 8'hBB); check("t7_l", out_last, 1);
        @(negedge clk);
        check("t7_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
